id_ex_hazard_reg: RTL

ID/EX pipeline register with built-in RAW hazard detection for the non-forwarding five-stage RV32I pipeline. It sits directly downstream of the decode control unit. Each cycle it either:
- captures the decoded instruction and its control bundle into EX, or
- holds fetch/decode with a stall and injects a bubble until every older in-flight writer of a source register has retired.

EX-stage redirects (taken branch, JAL, JALR) flush it.

---
 rtl/rv_pkg.sv | 50 +++++
 rtl/id_ex_hazard_reg_if.sv | 43 ++++
 rtl/hazard_scoreboard.sv | 50 +++++
 rtl/id_ex_hazard_reg.sv | 97 +++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I pipeline definitions.
//   - opcode constants for the base integer ISA
//   - ctrl_t: 15-bit decoded control bundle carried from ID into EX
//   - hist_t: one writer-history record {wr, rd}
//   - src_use(): which register sources an opcode reads
package rv_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef struct packed {
        logic       rd_wren;
        logic       mem_wren;
        logic       mem_rden;
        logic       op_a_sel;
        logic       insn_vld;
        logic       is_br;
        logic       wb_sel;
        logic [1:0] is_uncbr;
        logic [1:0] op_b_sel;
        logic [3:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    typedef struct packed {
        logic       wr;
        logic [4:0] rd;
    } hist_t;

    // Returns {use_rs1, use_rs2}. LUI, AUIPC, JAL and unknown opcodes read nothing.
    function automatic logic [1:0] src_use(input logic [6:0] opcode);
        logic [1:0] u;
        u = 2'b00;
        case (opcode)
            OPC_R, OPC_BRANCH, OPC_STORE: u = 2'b11;
            OPC_LOAD, OPC_OPIMM, OPC_JALR: u = 2'b10;
            default: u = 2'b00;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/id_ex_hazard_reg_if.sv
// ID/EX boundary bundle.
//   slave  : the ID/EX register (consumes decode-stage values, produces EX values and stall)
//   master : the surrounding pipeline (drives decode-stage values and flush)
interface id_ex_hazard_reg_if
    import rv_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int STALL_CNT_W = 16
);
    logic                   i_id_vld;
    logic [XLEN-1:0]        i_id_pc;
    logic [31:0]            i_id_instr;
    ctrl_t                  i_id_ctrl;
    logic [XLEN-1:0]        i_id_rs1_data;
    logic [XLEN-1:0]        i_id_rs2_data;
    logic [XLEN-1:0]        i_id_imm;
    logic                   i_ex_flush;

    logic                   o_stall;
    logic                   o_ex_vld;
    logic [XLEN-1:0]        o_ex_pc;
    logic [31:0]            o_ex_instr;
    ctrl_t                  o_ex_ctrl;
    logic [XLEN-1:0]        o_ex_rs1_data;
    logic [XLEN-1:0]        o_ex_rs2_data;
    logic [XLEN-1:0]        o_ex_imm;
    logic [STALL_CNT_W-1:0] o_stall_cnt;

    modport slave (
        input  i_id_vld, i_id_pc, i_id_instr, i_id_ctrl,
               i_id_rs1_data, i_id_rs2_data, i_id_imm, i_ex_flush,
        output o_stall, o_ex_vld, o_ex_pc, o_ex_instr, o_ex_ctrl,
               o_ex_rs1_data, o_ex_rs2_data, o_ex_imm, o_stall_cnt
    );

    modport master (
        output i_id_vld, i_id_pc, i_id_instr, i_id_ctrl,
               i_id_rs1_data, i_id_rs2_data, i_id_imm, i_ex_flush,
        input  o_stall, o_ex_vld, o_ex_pc, o_ex_instr, o_ex_ctrl,
               o_ex_rs1_data, o_ex_rs2_data, o_ex_imm, o_stall_cnt
    );

endinterface

// File: rtl/hazard_scoreboard.sv
// RAW hazard detection for a non-forwarding pipeline.
//   i_clk, i_rst_n     : clock, async active-low reset
//   i_rs1, i_rs2       : decode-stage source indices
//   i_use_rs1/rs2      : source actually read by the decode-stage opcode
//   i_ex_wr, i_ex_rd   : writer currently in EX
//   o_hazard           : some used nonzero source matches an in-flight writer
// MEM and WB records shift unconditionally; the register file is not
// write-through, so a WB writer still blocks the reader.
module hazard_scoreboard
    import rv_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [4:0] i_rs1,
    input  logic [4:0] i_rs2,
    input  logic       i_use_rs1,
    input  logic       i_use_rs2,
    input  logic       i_ex_wr,
    input  logic [4:0] i_ex_rd,
    output logic       o_hazard
);

    hist_t ex_ent;
    hist_t mem_q;
    hist_t wb_q;

    assign ex_ent = '{wr: i_ex_wr, rd: i_ex_rd};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            mem_q <= ex_ent;
            wb_q  <= mem_q;
        end
    end

    function automatic logic src_hit(input logic [4:0] rs, input logic use_rs,
                                     input hist_t e);
        return use_rs && (rs != 5'd0) && e.wr && (e.rd == rs);
    endfunction

    always_comb begin
        o_hazard = src_hit(i_rs1, i_use_rs1, ex_ent) || src_hit(i_rs1, i_use_rs1, mem_q)
                || src_hit(i_rs1, i_use_rs1, wb_q)   || src_hit(i_rs2, i_use_rs2, ex_ent)
                || src_hit(i_rs2, i_use_rs2, mem_q)  || src_hit(i_rs2, i_use_rs2, wb_q);
    end

endmodule

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with RAW stall/bubble insertion.
//   i_clk, i_rst_n : clock, async active-low reset
//   bus (slave)    : decode-stage inputs and flush in; EX-stage copies,
//                    combinational stall and saturating stall count out
// Every edge EX either captures the decode-stage instruction or takes a
// bubble (flush, stall, or nothing valid in ID).
module id_ex_hazard_reg
    import rv_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    id_ex_hazard_reg_if.slave bus
);

    logic                   ex_vld_q;
    logic [XLEN-1:0]        ex_pc_q;
    logic [31:0]            ex_instr_q;
    ctrl_t                  ex_ctrl_q;
    logic [XLEN-1:0]        ex_rs1_q;
    logic [XLEN-1:0]        ex_rs2_q;
    logic [XLEN-1:0]        ex_imm_q;
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    logic [1:0] use_src;
    logic       hazard;
    logic       stall;
    logic       capture;

    assign use_src = src_use(bus.i_id_instr[6:0]);

    // An illegal instruction sits in EX with ex_vld_q low, so it never counts as a writer.
    hazard_scoreboard u_sb (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_rs1     (bus.i_id_instr[19:15]),
        .i_rs2     (bus.i_id_instr[24:20]),
        .i_use_rs1 (use_src[1]),
        .i_use_rs2 (use_src[0]),
        .i_ex_wr   (ex_ctrl_q.rd_wren & ex_vld_q),
        .i_ex_rd   (ex_instr_q[11:7]),
        .o_hazard  (hazard)
    );

    // Flush wins: the decode-stage instruction is wrong-path, so there is nothing to hold.
    assign stall   = bus.i_id_vld & hazard & ~bus.i_ex_flush;
    assign capture = bus.i_id_vld & ~stall & ~bus.i_ex_flush;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ex_vld_q   <= 1'b0;
            ex_pc_q    <= '0;
            ex_instr_q <= '0;
            ex_ctrl_q  <= CTRL_BUBBLE;
            ex_rs1_q   <= '0;
            ex_rs2_q   <= '0;
            ex_imm_q   <= '0;
        end else if (capture) begin
            ex_vld_q   <= bus.i_id_ctrl.insn_vld;
            ex_pc_q    <= bus.i_id_pc;
            ex_instr_q <= bus.i_id_instr;
            ex_ctrl_q  <= bus.i_id_ctrl;
            ex_rs1_q   <= bus.i_id_rs1_data;
            ex_rs2_q   <= bus.i_id_rs2_data;
            ex_imm_q   <= bus.i_id_imm;
        end else begin
            ex_vld_q   <= 1'b0;
            ex_pc_q    <= '0;
            ex_instr_q <= '0;
            ex_ctrl_q  <= CTRL_BUBBLE;
            ex_rs1_q   <= '0;
            ex_rs2_q   <= '0;
            ex_imm_q   <= '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    assign bus.o_stall       = stall;
    assign bus.o_ex_vld      = ex_vld_q;
    assign bus.o_ex_pc       = ex_pc_q;
    assign bus.o_ex_instr    = ex_instr_q;
    assign bus.o_ex_ctrl     = ex_ctrl_q;
    assign bus.o_ex_rs1_data = ex_rs1_q;
    assign bus.o_ex_rs2_data = ex_rs2_q;
    assign bus.o_ex_imm      = ex_imm_q;
    assign bus.o_stall_cnt   = stall_cnt_q;

endmodule
